// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder: ALU opcodes and default geometry.
package cla_pkg;

    localparam int unsigned CLA_WIDTH   = 32;
    localparam int unsigned CLA_GROUP_W = 8;
    localparam int unsigned CLA_STAGES  = 2;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;

endpackage

// File: rtl/cla_group.sv
// One GROUP_W-bit carry-lookahead group: local sum from an external carry-in,
// plus group propagate/generate for the stage-level lookahead.
module cla_group
    import cla_pkg::*;
#(
    parameter int unsigned GROUP_W = CLA_GROUP_W
) (
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] s,
    output logic               p,
    output logic               g
);

    logic [GROUP_W-1:0] bit_p;
    logic [GROUP_W-1:0] bit_g;
    logic [GROUP_W-1:0] carry;

    assign bit_p = a ^ b;
    assign bit_g = a & b;

    // Each bit carry as a flat sum of products, so no carry depends on another.
    always_comb begin : bit_lookahead
        logic acc;
        logic prod;
        carry = '0;
        acc   = 1'b0;
        prod  = 1'b0;
        for (int i = 0; i < int'(GROUP_W); i++) begin
            prod = cin;
            for (int m = 0; m < i; m++) prod = prod & bit_p[m];
            acc = prod;
            for (int j = 0; j < i; j++) begin
                prod = bit_g[j];
                for (int m = j + 1; m < i; m++) prod = prod & bit_p[m];
                acc = acc | prod;
            end
            carry[i] = acc;
        end
    end

    always_comb begin : group_generate
        logic prod;
        g    = 1'b0;
        prod = 1'b0;
        for (int j = 0; j < int'(GROUP_W); j++) begin
            prod = bit_g[j];
            for (int m = j + 1; m < int'(GROUP_W); m++) prod = prod & bit_p[m];
            g = g | prod;
        end
    end

    assign p = &bit_p;
    assign s = bit_p ^ carry;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Define SATURATE_EN to clamp overflowing results to the signed extreme instead of wrapping.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH   = CLA_WIDTH,
    parameter int unsigned GROUP_W = CLA_GROUP_W,
    parameter int unsigned STAGES  = CLA_STAGES
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NG   = WIDTH / GROUP_W;
    localparam int unsigned GPS  = NG / STAGES;
    localparam int unsigned SW   = GPS * GROUP_W;
    localparam int unsigned LAST = STAGES - 1;
    localparam int unsigned MIDS = (STAGES > 1) ? STAGES - 1 : 1;

    logic                sub;
    logic [STAGES-1:0]   stg_valid;
    logic [STAGES-1:0]   valid_in;
    logic [STAGES:0]     ready;

    // Inter-stage registers: operands shifted down as they are consumed, sum filled from the top.
    logic [WIDTH-1:0]    stg_a   [MIDS];
    logic [WIDTH-1:0]    stg_bx  [MIDS];
    logic [WIDTH-1:0]    stg_sum [MIDS];
    logic [MIDS-1:0]     stg_carry;

    logic [WIDTH-1:0]    a_cur   [STAGES];
    logic [WIDTH-1:0]    bx_cur  [STAGES];
    logic [WIDTH-1:0]    sum_cur [STAGES];
    logic [WIDTH-1:0]    sum_nxt [STAGES];
    logic [STAGES-1:0]   cin_cur;
    logic [STAGES-1:0]   cout_nxt;

    logic                a_sign;
    logic                b_sign;
    logic [WIDTH-1:0]    s_raw;
    logic [WIDTH-1:0]    s_fin;
    logic                ovf_raw;

    logic [WIDTH-1:0]    s_q;
    logic                cout_q;
    logic                ovf_q;
    logic                zero_q;

    assign sub = |(opcode & ALU_SUB);

    // A stage can take new contents when it is empty or its successor is taking its current ones.
    always_comb begin
        ready         = '0;
        ready[STAGES] = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            ready[k] = !stg_valid[k] || ready[k+1];
        end
    end

    always_comb begin
        valid_in    = '0;
        valid_in[0] = in_valid;
        for (int k = 1; k < int'(STAGES); k++) valid_in[k] = stg_valid[k-1];
    end

    assign a_cur[0]   = A;
    assign bx_cur[0]  = B ^ {WIDTH{sub}};
    assign sum_cur[0] = '0;
    assign cin_cur[0] = sub;

    for (genvar k = 1; k < STAGES; k++) begin : gen_stage_in
        assign a_cur[k]   = stg_a[k-1];
        assign bx_cur[k]  = stg_bx[k-1];
        assign sum_cur[k] = stg_sum[k-1];
        assign cin_cur[k] = stg_carry[k-1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        logic [SW-1:0]  st_sum;
        logic [GPS-1:0] gp;
        logic [GPS-1:0] gg;
        logic [GPS:0]   gc;

        for (genvar g = 0; g < GPS; g++) begin : gen_group
            cla_group #(.GROUP_W(GROUP_W)) u_group (
                .a   (a_cur[k][g*GROUP_W +: GROUP_W]),
                .b   (bx_cur[k][g*GROUP_W +: GROUP_W]),
                .cin (gc[g]),
                .s   (st_sum[g*GROUP_W +: GROUP_W]),
                .p   (gp[g]),
                .g   (gg[g])
            );
        end

        // Second lookahead level: group carries straight from group P/G and the stage carry-in.
        always_comb begin : stage_lookahead
            logic acc;
            logic prod;
            gc    = '0;
            gc[0] = cin_cur[k];
            acc   = 1'b0;
            prod  = 1'b0;
            for (int i = 0; i < int'(GPS); i++) begin
                prod = cin_cur[k];
                for (int m = 0; m <= i; m++) prod = prod & gp[m];
                acc = prod;
                for (int j = 0; j <= i; j++) begin
                    prod = gg[j];
                    for (int m = j + 1; m <= i; m++) prod = prod & gp[m];
                    acc = acc | prod;
                end
                gc[i+1] = acc;
            end
        end

        assign sum_nxt[k]  = WIDTH'({st_sum, sum_cur[k]} >> SW);
        assign cout_nxt[k] = gc[GPS];
    end

    if (STAGES > 1) begin : gen_last_upper
        logic unused_upper;
        assign unused_upper = ^{a_cur[LAST][WIDTH-1:SW], bx_cur[LAST][WIDTH-1:SW]};
    end

    // The last stage holds the operand MSBs in its low slice.
    assign a_sign  = a_cur[LAST][SW-1];
    assign b_sign  = bx_cur[LAST][SW-1];
    assign s_raw   = sum_nxt[LAST];
    assign ovf_raw = (a_sign == b_sign) && (s_raw[WIDTH-1] != a_sign);

`ifdef SATURATE_EN
    always_comb begin
        s_fin = s_raw;
        if (ovf_raw) begin
            s_fin = a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign s_fin = s_raw;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stg_valid <= '0;
            stg_carry <= '0;
            for (int k = 0; k < int'(MIDS); k++) begin
                stg_a[k]   <= '0;
                stg_bx[k]  <= '0;
                stg_sum[k] <= '0;
            end
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (ready[k]) stg_valid[k] <= valid_in[k];
            end
            for (int k = 0; k < int'(STAGES) - 1; k++) begin
                if (ready[k] && valid_in[k]) begin
                    stg_a[k]     <= a_cur[k] >> SW;
                    stg_bx[k]    <= bx_cur[k] >> SW;
                    stg_sum[k]   <= sum_nxt[k];
                    stg_carry[k] <= cout_nxt[k];
                end
            end
            if (ready[LAST] && valid_in[LAST]) begin
                s_q    <= s_fin;
                cout_q <= cout_nxt[LAST];
                ovf_q  <= ovf_raw;
                zero_q <= (s_fin == '0);
            end
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = stg_valid[LAST];
    assign S         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: directed add/sub, carries, overflow, stalls and reset.
module tb_pipelined_cla_adder;

    localparam int unsigned W  = 32;
    localparam int unsigned ST = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [4:0]    opcode = 5'b00000;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  S;
    logic          cout;
    logic          ovf;
    logic          zero;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;

    pipelined_cla_adder #(.WIDTH(W), .GROUP_W(8), .STAGES(ST)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] op);
        exp_t       r;
        logic [W-1:0] bx;
        logic [W:0]   full;
        bx     = b ^ {W{op[0]}};
        full   = {1'b0, a} + {1'b0, bx} + {32'd0, op[0]};
        r.cout = full[W];
        r.s    = full[W-1:0];
        r.ovf  = (a[W-1] == bx[W-1]) && (full[W-1] != a[W-1]);
`ifdef SATURATE_EN
        if (r.ovf) r.s = a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        r.zero = (r.s == 32'd0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one op from just after a rising edge; returns just after the edge that accepted it.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] op);
        int cyc;
        cyc      = 0;
        in_valid = 1'b1;
        A        = a;
        B        = b;
        opcode   = op;
        @(negedge clock);
        while (!in_ready && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        if (in_ready) sb.push_back(model(a, b, op));
        else check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < 100) begin
            @(posedge clock);
            cyc++;
        end
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic expect_latency(input string tag, input logic [W-1:0] s_exp);
        for (int i = 0; i < int'(ST) - 1; i++) begin
            @(negedge clock);
            check({tag, "_early"}, 32'(out_valid), 32'd0);
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_S"}, S, s_exp);
        @(posedge clock);
        #1;
    endtask

    // Output-side scoreboard: compare every result transfer against the oldest pending expectation.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("no_pending", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_S", S, e.s);
                check("res_cout", 32'(cout), 32'(e.cout));
                check("res_ovf", 32'(ovf), 32'(e.ovf));
                check("res_zero", 32'(zero), 32'(e.zero));
            end
        end
    end

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t held;
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_S", S, 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic add with exact latency.
        issue(32'h0000_0005, 32'h0000_0003, 5'b00000);
        expect_latency("add_lat", 32'h0000_0008);
        drain();

        // Directed add/sub cases, back to back.
        issue(32'h1234_5678, 32'h1234_5678, 5'b00001);
        issue(32'h0000_FFFF, 32'h0000_0001, 5'b00000);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 5'b00000);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 5'b00000);
        issue(32'h8000_0000, 32'h0000_0001, 5'b00001);
        issue(32'h0000_0000, 32'h0000_0001, 5'b00001);
        issue(32'h00FF_FFFF, 32'h0000_0001, 5'b10110);
        drain();

        for (int i = 0; i < 12; i++) begin
            issue(32'($urandom), 32'($urandom), 5'($urandom_range(0, 31)));
        end
        drain();

        // Backpressure: two accepts fill the pipe, then the input stalls and the output holds.
        out_ready = 1'b0;
        issue(32'h0000_0010, 32'h0000_0020, 5'b00000);
        issue(32'h0000_0100, 32'h0000_0001, 5'b00001);
        held     = sb[0];
        in_valid = 1'b1;
        A        = 32'h8000_0000;
        B        = 32'h8000_0000;
        opcode   = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_S_hold", S, held.s);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        issue(32'h8000_0000, 32'h8000_0000, 5'b00000);
        issue(32'hDEAD_BEEF, 32'h0000_0011, 5'b00001);
        drain();

        // Reset with two ops in flight.
        issue(32'h0000_0001, 32'h0000_0002, 5'b00000);
        issue(32'h0000_0003, 32'h0000_0004, 5'b00000);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_S", S, 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        check("mid_rst_zero", 32'(zero), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        issue(32'h0000_0100, 32'h0000_0023, 5'b00000);
        expect_latency("post_rst_lat", 32'h0000_0123);
        drain();
        repeat (3) @(posedge clock);
        #1;
        check("no_stale", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
